// File: rtl/ray_sphere_normal_normalize.sv
// ray_sphere_normal_normalize: turns an unnormalized hit normal (three signed
// Q16.16 components) into a unit-length normal. Squared length is accumulated
// over 3 cycles, a restoring square root takes 32 cycles, and each component
// is then divided by the length with an 18-cycle restoring division.
// Optional macro NORM_ROUND_EN: round the quotient half away from zero
// instead of truncating it.
module ray_sphere_normal_normalize #(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [95:0]      in_vec,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [95:0]      out_vec,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned COMP_W  = 32;
    localparam int unsigned VEC_W   = 96;
    localparam int unsigned ACC_W   = 64;
    localparam int unsigned SQREM_W = 34;
    localparam int unsigned QUO_W   = 18;
    localparam int unsigned CNT_W   = 5;
    localparam logic [COMP_W-1:0] ONE_Q16 = 32'h0001_0000;

    typedef enum logic [2:0] {S_IDLE, S_DOT, S_SQRT, S_DIV, S_FIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [VEC_W-1:0]     mag_q, mag_d;
    logic [2:0]           sign_q, sign_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [SQREM_W-1:0]   sq_rem_q, sq_rem_d;
    logic [COMP_W-1:0]    root_q, root_d;
    logic [COMP_W-1:0]    dv_rem_q, dv_rem_d;
    logic [QUO_W-1:0]     dv_lo_q, dv_lo_d;
    logic [QUO_W-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           comp_q, comp_d;
    logic [VEC_W-1:0]     res_q, res_d;
    logic [VEC_W-1:0]     out_vec_q, out_vec_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic                 out_zero_q, out_zero_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic [COMP_W-1:0]    mag_cur, mag_nxt, comp_res;
    logic [SQREM_W+1:0]   sq_rem_sh, sq_trial;
    logic                 sq_bit;
    logic [COMP_W-1:0]    root_nxt;
    logic [COMP_W:0]      dv_rem_sh, dv_len;
    logic                 dv_bit;
    logic [QUO_W-1:0]     quo_nxt;

    // Component select: index 0 = x (top word), 1 = y, 2 = z.
    function automatic logic [COMP_W-1:0] pick(input logic [VEC_W-1:0] v, input logic [1:0] i);
        case (i)
            2'd0:    pick = v[95:64];
            2'd1:    pick = v[63:32];
            default: pick = v[31:0];
        endcase
    endfunction

    function automatic logic sign_of(input logic [2:0] s, input logic [1:0] i);
        case (i)
            2'd0:    sign_of = s[2];
            2'd1:    sign_of = s[1];
            default: sign_of = s[0];
        endcase
    endfunction

    // Magnitude as unsigned; 0x80000000 stays 0x80000000 (= 2^31).
    function automatic logic [COMP_W-1:0] abs32(input logic [COMP_W-1:0] v);
        abs32 = v[COMP_W-1] ? (~v + 32'd1) : v;
    endfunction

    // Q16.17 quotient -> signed Q16.16 result, clamped to 1.0.
    function automatic logic [COMP_W-1:0] finish_comp(input logic [QUO_W-1:0] q, input logic neg);
        logic [QUO_W:0]    qr;
        logic [16:0]       r;
        logic [COMP_W-1:0] m;
`ifdef NORM_ROUND_EN
        qr = 19'(q) + 19'd1;
`else
        qr = 19'(q);
`endif
        r  = 17'(qr >> 1);
        m  = (32'(r) > ONE_Q16) ? ONE_Q16 : 32'(r);
        finish_comp = neg ? (~m + 32'd1) : m;
    endfunction

    // Next-state and datapath step for the whole pipeline.
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        tag_d       = tag_q;
        acc_d       = acc_q;
        sq_rem_d    = sq_rem_q;
        root_d      = root_q;
        dv_rem_d    = dv_rem_q;
        dv_lo_d     = dv_lo_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        comp_d      = comp_q;
        res_d       = res_q;
        out_vec_d   = out_vec_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;
        out_valid_d = out_valid_q;
        mag_cur     = pick(mag_q, comp_q);
        mag_nxt     = '0;
        comp_res    = '0;
        sq_rem_sh   = {sq_rem_q, acc_q[63:62]};
        sq_trial    = {2'b00, root_q, 2'b01};
        sq_bit      = (sq_rem_sh >= sq_trial);
        root_nxt    = {root_q[30:0], sq_bit};
        dv_rem_sh   = {dv_rem_q, dv_lo_q[QUO_W-1]};
        dv_len      = {1'b0, root_q};
        dv_bit      = (dv_rem_sh >= dv_len);
        quo_nxt     = {quo_q[QUO_W-2:0], dv_bit};

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mag_d      = {abs32(in_vec[95:64]), abs32(in_vec[63:32]), abs32(in_vec[31:0])};
                    sign_d     = {in_vec[95], in_vec[63], in_vec[31]};
                    tag_d      = in_tag;
                    acc_d      = '0;
                    comp_d     = '0;
                    res_d      = '0;
                    out_zero_d = 1'b0;
                    state_d    = S_DOT;
                end
            end
            S_DOT: begin
                acc_d = acc_q + 64'(mag_cur) * 64'(mag_cur);
                if (comp_q == 2'd2) begin
                    comp_d   = '0;
                    cnt_d    = '0;
                    sq_rem_d = '0;
                    root_d   = '0;
                    state_d  = S_SQRT;
                end else begin
                    comp_d = comp_q + 2'd1;
                end
            end
            S_SQRT: begin
                acc_d    = acc_q << 2;
                sq_rem_d = sq_bit ? 34'(sq_rem_sh - sq_trial) : 34'(sq_rem_sh);
                root_d   = root_nxt;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    cnt_d  = '0;
                    comp_d = '0;
                    if (root_nxt == '0) begin
                        state_d = S_FIN;
                    end else begin
                        mag_nxt  = pick(mag_q, 2'd0);
                        dv_rem_d = mag_nxt >> 1;
                        dv_lo_d  = {mag_nxt[0], 17'd0};
                        quo_d    = '0;
                        state_d  = S_DIV;
                    end
                end
            end
            S_DIV: begin
                dv_rem_d = dv_bit ? 32'(dv_rem_sh - dv_len) : 32'(dv_rem_sh);
                dv_lo_d  = {dv_lo_q[QUO_W-2:0], 1'b0};
                quo_d    = quo_nxt;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd17) begin
                    comp_res = finish_comp(quo_nxt, sign_of(sign_q, comp_q));
                    case (comp_q)
                        2'd0:    res_d[95:64] = comp_res;
                        2'd1:    res_d[63:32] = comp_res;
                        default: res_d[31:0]  = comp_res;
                    endcase
                    cnt_d = '0;
                    if (comp_q == 2'd2) begin
                        state_d = S_FIN;
                    end else begin
                        comp_d   = comp_q + 2'd1;
                        mag_nxt  = pick(mag_q, comp_q + 2'd1);
                        dv_rem_d = mag_nxt >> 1;
                        dv_lo_d  = {mag_nxt[0], 17'd0};
                        quo_d    = '0;
                    end
                end
            end
            S_FIN: begin
                out_vec_d   = res_q;
                out_tag_d   = tag_q;
                out_zero_d  = (root_q == '0);
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any vector in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mag_q       <= '0;
            sign_q      <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            sq_rem_q    <= '0;
            root_q      <= '0;
            dv_rem_q    <= '0;
            dv_lo_q     <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            comp_q      <= '0;
            res_q       <= '0;
            out_vec_q   <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            sq_rem_q    <= sq_rem_d;
            root_q      <= root_d;
            dv_rem_q    <= dv_rem_d;
            dv_lo_q     <= dv_lo_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            comp_q      <= comp_d;
            res_q       <= res_d;
            out_vec_q   <= out_vec_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_vec   = out_vec_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ray_sphere_normal_normalize.sv
// Directed bench for ray_sphere_normal_normalize with hand-computed results.
// Honours NORM_ROUND_EN for the rounded expectations.
module tb_ray_sphere_normal_normalize;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] in_vec = '0;
    logic [7:0]  in_tag = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] out_vec;
    logic [7:0]  out_tag;
    logic        out_zero;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    ray_sphere_normal_normalize #(.TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_vec(in_vec), .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
        .out_vec(out_vec), .out_tag(out_tag), .out_zero(out_zero),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus only: wait for in_ready, present one vector, record the accept cycle.
    task automatic send(input logic [95:0] v, input logic [7:0] t);
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        in_vec = v; in_tag = t; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Stimulus only: wait (bounded) for out_valid, return cycles since accept.
    task automatic wait_out(output int lat);
        while (out_valid !== 1'b1 && (cyc - acc_cyc) < 300) @(negedge clk);
        lat = cyc - acc_cyc;
    endtask

    // Stimulus only: one output handshake, then settle at the next negedge.
    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        asserts++; if (out_vec !== 96'd0) begin fails++; $display("FAIL reset_out_vec got=%h exp=0", out_vec); end
        asserts++; if (out_tag !== 8'd0) begin fails++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        asserts++; if (out_zero !== 1'b0) begin fails++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
    endtask

    task automatic test_basic();
        int lat;
        logic [95:0] exp_v;
`ifdef NORM_ROUND_EN
        exp_v = {32'h0000999A, 32'h0000CCCD, 32'h00000000};
`else
        exp_v = {32'h00009999, 32'h0000CCCC, 32'h00000000};
`endif
        send({32'h00030000, 32'h00040000, 32'h00000000}, 8'h5A);
        wait_out(lat);
        asserts++; if (lat != 90) begin fails++; $display("FAIL basic_latency got=%0d exp=90", lat); end
        asserts++; if (out_vec !== exp_v) begin fails++; $display("FAIL basic_vec got=%h exp=%h", out_vec, exp_v); end
        asserts++; if (out_tag !== 8'h5A) begin fails++; $display("FAIL basic_tag got=%h exp=5a", out_tag); end
        asserts++; if (out_zero !== 1'b0) begin fails++; $display("FAIL basic_zero got=%b exp=0", out_zero); end
        consume();
        asserts++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_negative();
        int lat;
        logic [95:0] exp_v;
`ifdef NORM_ROUND_EN
        exp_v = {32'hFFFF6666, 32'h00000000, 32'h0000CCCD};
`else
        exp_v = {32'hFFFF6667, 32'h00000000, 32'h0000CCCC};
`endif
        send({32'hFFFD0000, 32'h00000000, 32'h00040000}, 8'h22);
        wait_out(lat);
        asserts++; if (lat != 90) begin fails++; $display("FAIL neg_latency got=%0d exp=90", lat); end
        asserts++; if (out_vec !== exp_v) begin fails++; $display("FAIL neg_vec got=%h exp=%h", out_vec, exp_v); end
        consume();
    endtask

    task automatic test_extremes();
        logic [95:0] vin [4];
        logic [95:0] vexp [4];
        int lat;
        vin[0] = {32'h80000000, 32'h00000000, 32'h00000000};
        vexp[0] = {32'hFFFF0000, 32'h00000000, 32'h00000000};
        vin[1] = {32'h00000001, 32'h00000000, 32'h00000000};
        vexp[1] = {32'h00010000, 32'h00000000, 32'h00000000};
        vin[2] = {32'h00000000, 32'hFFFF0000, 32'h00000000};
        vexp[2] = {32'h00000000, 32'hFFFF0000, 32'h00000000};
        vin[3] = {32'h00000000, 32'h00000000, 32'h7FFFFFFF};
        vexp[3] = {32'h00000000, 32'h00000000, 32'h00010000};
        for (int i = 0; i < 4; i++) begin
            send(vin[i], 8'(8'h30 + i));
            wait_out(lat);
            asserts++; if (lat != 90) begin fails++; $display("FAIL extreme%0d_latency got=%0d exp=90", i, lat); end
            asserts++; if (out_vec !== vexp[i]) begin fails++; $display("FAIL extreme%0d_vec got=%h exp=%h", i, out_vec, vexp[i]); end
            asserts++; if (out_tag !== 8'(8'h30 + i)) begin fails++; $display("FAIL extreme%0d_tag got=%h exp=%h", i, out_tag, 8'(8'h30 + i)); end
            consume();
        end
    endtask

    task automatic test_zero();
        int lat;
        send(96'd0, 8'h11);
        wait_out(lat);
        asserts++; if (lat != 36) begin fails++; $display("FAIL zero_latency got=%0d exp=36", lat); end
        asserts++; if (out_vec !== 96'd0) begin fails++; $display("FAIL zero_vec got=%h exp=0", out_vec); end
        asserts++; if (out_zero !== 1'b1) begin fails++; $display("FAIL zero_flag got=%b exp=1", out_zero); end
        asserts++; if (out_tag !== 8'h11) begin fails++; $display("FAIL zero_tag got=%h exp=11", out_tag); end
        consume();
        // A new accept must clear the sticky zero flag.
        send({32'h00030000, 32'h00040000, 32'h00000000}, 8'h12);
        @(negedge clk);
        asserts++; if (out_zero !== 1'b0) begin fails++; $display("FAIL zero_clear got=%b exp=0", out_zero); end
        wait_out(lat);
        asserts++; if (lat != 90) begin fails++; $display("FAIL zero_next_latency got=%0d exp=90", lat); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        logic [95:0] snap_v;
        logic [7:0]  snap_t;
        logic [95:0] exp_b;
`ifdef NORM_ROUND_EN
        exp_b = {32'h00000000, 32'h00006276, 32'hFFFF13B1};
`else
        exp_b = {32'h00000000, 32'h00006276, 32'hFFFF13B2};
`endif
        send({32'h00030000, 32'h00040000, 32'h00000000}, 8'h21);
        wait_out(lat);
        snap_v = out_vec;
        snap_t = out_tag;
        asserts++; if (snap_v !== {32'h00009999 + 32'(`ifdef NORM_ROUND_EN 1 `else 0 `endif), 32'h0000CCCC + 32'(`ifdef NORM_ROUND_EN 1 `else 0 `endif), 32'h0})
            begin fails++; $display("FAIL bp_first_vec got=%h", snap_v); end
        in_vec = {32'h00000000, 32'h00050000, 32'hFFF40000};
        in_tag = 8'h77;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_vec !== snap_v || out_tag !== snap_t || in_ready !== 1'b0) bad++;
        end
        asserts++; if (bad != 0) begin fails++; $display("FAIL bp_hold bad_cycles=%0d exp=0 (valid=%b ready=%b)", bad, out_valid, in_ready); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        asserts++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        wait_out(lat);
        asserts++; if (lat != 90) begin fails++; $display("FAIL bp_second_latency got=%0d exp=90", lat); end
        asserts++; if (out_vec !== exp_b) begin fails++; $display("FAIL bp_second_vec got=%h exp=%h", out_vec, exp_b); end
        asserts++; if (out_tag !== 8'h77) begin fails++; $display("FAIL bp_second_tag got=%h exp=77", out_tag); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen = 1'b0;
        logic [95:0] exp_v;
`ifdef NORM_ROUND_EN
        exp_v = {32'h0000999A, 32'h0000CCCD, 32'h00000000};
`else
        exp_v = {32'h00009999, 32'h0000CCCC, 32'h00000000};
`endif
        send({32'h00030000, 32'h00040000, 32'h00000000}, 8'h33);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        asserts++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL midrst_state got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        asserts++; if (seen) begin fails++; $display("FAIL midrst_emitted got out_valid=1 exp none"); end
        send({32'h00030000, 32'h00040000, 32'h00000000}, 8'h44);
        wait_out(lat);
        asserts++; if (lat != 90) begin fails++; $display("FAIL midrst_latency got=%0d exp=90", lat); end
        asserts++; if (out_vec !== exp_v) begin fails++; $display("FAIL midrst_vec got=%h exp=%h", out_vec, exp_v); end
        asserts++; if (out_tag !== 8'h44) begin fails++; $display("FAIL midrst_tag got=%h exp=44", out_tag); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_extremes();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/ray_sphere_normal_normalize.md
Name: ray_sphere_normal_normalize

Overview:
- Multi-cycle stage directly downstream of the sphere-normal pipeline.
- Takes the unnormalized hit normal (hit position minus sphere centre) and produces a unit-length normal for shading.
- Iterative datapath: squared length, then bit-serial square root, then bit-serial division per component.
- Ready/valid handshake both sides, one vector in flight at a time, optional sideband tag carried through.

Parameters:
- TAG_W, 8: width of the sideband tag (e.g. hit/pixel id), passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_vec  in  96  unnormalized normal; [95:64]=x, [63:32]=y, [31:0]=z; each signed Q16.16
- in_tag  in  TAG_W  sideband, captured with in_vec
- in_valid  in  1  in_vec/in_tag valid
- in_ready  out  1  block can accept a vector
- out_vec  out  96  normalized vector, same packing/format
- out_tag  out  TAG_W  captured in_tag
- out_zero  out  1  input had zero length; out_vec forced to 0
- out_valid  out  1  outputs valid, held until consumed
- out_ready  in  1  downstream accepts output

Behaviour:
- Reset: state=IDLE; out_vec=0, out_tag=0, out_zero=0, out_valid=0; in_ready=1 on the cycle after reset deasserts. Reset mid-operation aborts the vector silently; nothing is emitted.
- in_ready=1 only in IDLE. Accept on edge with in_valid&in_ready. Capture vec, tag, and the sign of each component. Compute absolute values as 32-bit unsigned; 0x80000000 maps to 2^31.
- DOT, 3 cycles: one component per cycle; acc64 += mag*mag (unsigned 64-bit, Q32.32). Max 3*2^62 does not overflow.
- SQRT, 32 cycles: restoring bit-serial integer sqrt of acc64, one result bit per cycle MSB-first. Result len is 32-bit unsigned Q16.16, floor of the exact value.
- If len==0 after SQRT: skip DIV, go to DONE with out_vec=0 and out_zero=1. This path has latency 3+32+1=36.
- DIV, 3x18 = 54 cycles, components x, y, z in order. Restoring division of (mag<<17)/len gives an 18-bit quotient q = result in Q16.17 (17 integer-range bits plus guard). Since mag<=len, q<=2^17.
  - Truncate mode: res = q>>1.
  - Saturate res to 0x00010000.
  - Apply the captured sign by two's complement.
- DONE: out_* registered and out_valid=1. Outputs are stable while out_valid&!out_ready. On out_valid&out_ready edge: out_valid=0, state=IDLE, in_ready=1 the next cycle. No same-cycle turnaround: an accept can never coincide with an output handshake.
- Latency, accept edge to edge where out_valid rises: 3+32+54+1 = 90 cycles (non-zero input). Throughput: one vector per ≥91 cycles.
- in_valid while busy is ignored; the upstream must hold its data (standard valid/ready).
- out_zero is cleared on every new accept.

Optional Feature:
- Macro NORM_ROUND_EN.
- Defined: res = (q+1)>>1 (round half away from zero on magnitude), then saturate to 0x00010000 and apply sign. Latency unchanged.
- Undefined: truncation toward zero as in Behaviour.

Test Plan:
- Reset, then x=0x00030000, y=0x00040000, z=0, tag=0x5A -> after exactly 90 cycles: out_vec = {0x00009999, 0x0000CCCC, 0x00000000}, out_tag=0x5A, out_zero=0. With NORM_ROUND_EN: {0x0000999A, 0x0000CCCD, 0}.
- x=0xFFFD0000 (-3), y=0, z=0x00040000 -> {0xFFFF6667, 0, 0x0000CCCC} in truncate mode.
- Axis and extremes:
  - x=0x80000000, y=z=0 -> {0xFFFF0000, 0, 0}.
  - x=0x00000001, y=z=0 -> {0x00010000, 0, 0}, exercising saturation/exact case.
- Zero vector, tag=0x11 -> out_valid after 36 cycles, out_vec=0, out_zero=1, out_tag=0x11.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid: outputs stable, in_ready=0, and a second in_valid is not accepted.
  - Release: one output handshake, in_ready=1 the next cycle, then the second vector is accepted.
- Assert rst during SQRT: out_valid stays 0, in_ready=1 after reset. A following vector {0x00030000, 0x00040000, 0} yields the correct result with latency 90.
